// File: rtl/d_flip_flop_pkg.sv
// Shared constants for the loadable storage register.
// Imported by the register and its signal bundle.
package d_flip_flop_pkg;

  localparam int DFF_WIDTH = 1;

  function automatic logic [DFF_WIDTH-1:0] dff_zero();
    return '0;
  endfunction

endpackage

// File: rtl/d_flip_flop_if.sv
// Data/enable bundle for a d_flip_flop instance.
// master drives data and enable; slave is the register.
interface d_flip_flop_if
  import d_flip_flop_pkg::*;
#(
  parameter int WIDTH = DFF_WIDTH
) ();

  logic [WIDTH-1:0] d_in;
  logic [WIDTH-1:0] d_out;
  logic             load;

  modport master (
    output d_in,
    output load,
    input  d_out
  );

  modport slave (
    input  d_in,
    input  load,
    output d_out
  );

endinterface

// File: rtl/d_flip_flop.sv
// Loadable D register with asynchronous active-high reset.
// Priority: rst, then load, then hold.
module d_flip_flop
  import d_flip_flop_pkg::*;
#(
  parameter int             WIDTH     = DFF_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  output logic [WIDTH-1:0] d_out,
  input  logic [WIDTH-1:0] d_in,
  input  logic             load,
  input  logic             rst,
  input  logic             clk
);

  // Mux form lets an unknown load merge d_in with the held value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_out <= RESET_VAL;
    end else begin
      d_out <= load ? d_in : d_out;
    end
  end

endmodule

// File: tb/tb_d_flip_flop.sv
// Self-checking bench for d_flip_flop: vector table,
// timing corner sequences and a randomized reference model.
module tb_d_flip_flop;

  logic clk;
  logic rst_a;
  logic rst_b;
  int   errors;
  int   checks;

  d_flip_flop_if #(.WIDTH(1)) a_if ();
  d_flip_flop_if #(.WIDTH(8)) b_if ();

  d_flip_flop #(
    .WIDTH(1)
  ) dut_a (
    .d_out(a_if.d_out),
    .d_in (a_if.d_in),
    .load (a_if.load),
    .rst  (rst_a),
    .clk  (clk)
  );

  d_flip_flop #(
    .WIDTH    (8),
    .RESET_VAL(8'hA5)
  ) dut_b (
    .d_out(b_if.d_out),
    .d_in (b_if.d_in),
    .load (b_if.load),
    .rst  (rst_b),
    .clk  (clk)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic rst;
    logic load;
    logic d_in;
    logic exp;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(
    input string      name,
    input logic [7:0] act,
    input logic [7:0] exp
  );
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t",
               name, act, exp, $time);
    end
  endtask

  initial begin
    logic [7:0] model;
    logic       r;
    logic       l;
    logic [7:0] d;

    errors = 0;
    checks = 0;
    rst_a = 1'b1;
    rst_b = 1'b1;
    a_if.d_in = 1'b0;
    a_if.load = 1'b0;
    b_if.d_in = 8'h00;
    b_if.load = 1'b0;

    #1;
    chk("reset_a", {7'd0, a_if.d_out}, 8'h00);
    chk("reset_b", b_if.d_out, 8'hA5);

    vecs[0] = '{1'b1, 1'b1, 1'b1, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 1'b1, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 1'b1, 1'b1};
    vecs[4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 1'b1, 1'b1, 1'b1};
    vecs[6] = '{1'b0, 1'b0, 1'b0, 1'b1};
    vecs[7] = '{1'b0, 1'b0, 1'b0, 1'b1};
    vecs[8] = '{1'b0, 1'b0, 1'b0, 1'b1};
    vecs[9] = '{1'b1, 1'b0, 1'b0, 1'b0};

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i > 0)
        chk($sformatf("vec%0d_mid", i - 1),
            {7'd0, a_if.d_out}, {7'd0, vecs[i-1].exp});
      rst_a = vecs[i].rst;
      a_if.load = vecs[i].load;
      a_if.d_in = vecs[i].d_in;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d", i),
          {7'd0, a_if.d_out}, {7'd0, vecs[i].exp});
    end

    // Async assert between edges.
    @(negedge clk);
    rst_a = 1'b0;
    a_if.load = 1'b1;
    a_if.d_in = 1'b1;
    @(posedge clk);
    #1;
    chk("async_pre", {7'd0, a_if.d_out}, 8'h01);
    @(negedge clk);
    #2;
    rst_a = 1'b1;
    #1;
    chk("async_rst", {7'd0, a_if.d_out}, 8'h00);

    // Release 2 ns after an edge: that edge must not capture.
    @(posedge clk);
    #2;
    rst_a = 1'b0;
    #1;
    chk("release_hold", {7'd0, a_if.d_out}, 8'h00);
    @(negedge clk);
    chk("release_mid", {7'd0, a_if.d_out}, 8'h00);
    @(posedge clk);
    #1;
    chk("release_cap", {7'd0, a_if.d_out}, 8'h01);

    // Wide instance with non-zero reset value.
    @(negedge clk);
    rst_b = 1'b0;
    b_if.load = 1'b1;
    b_if.d_in = 8'h3C;
    @(posedge clk);
    #1;
    chk("w8_load", b_if.d_out, 8'h3C);
    @(negedge clk);
    b_if.load = 1'b0;
    b_if.d_in = 8'hFF;
    @(posedge clk);
    #1;
    chk("w8_hold", b_if.d_out, 8'h3C);
    @(negedge clk);
    rst_b = 1'b1;
    #1;
    chk("w8_rst", b_if.d_out, 8'hA5);

    // Randomized run against a value-tracking model.
    model = 8'hA5;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      r = ($urandom_range(0, 9) == 0);
      l = 1'($urandom);
      d = 8'($urandom);
      rst_b = r;
      b_if.load = l;
      b_if.d_in = d;
      if (r) model = 8'hA5;
      #1;
      chk("rand_async", b_if.d_out, model);
      @(posedge clk);
      if (!r && l) model = d;
      #1;
      chk($sformatf("rand%0d", i), b_if.d_out, model);
    end

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
